ra_sdr_32x32_drv: RTL and testbench
===================================

Name: ra_sdr_32x32_drv

Overview:
- Initiator-side traffic generator and checker for the 2R1W 32x32 SDR test array.
- Drives the array's wr0/rd0/rd1 ports with a deterministic address/data sequence, then captures both read ports and compares against expected data.
- Reports busy/done, an error count and the first failing location.
- Sits between the host/test logic and the test array's functional ports, as the requester for the array responder.

Parameters:
- RD_LAT, 1, cycles from rd_enb_x asserted to rd_dat_x valid (legal 1..4).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; ignored while busy.
- mode  in  2  sequence select: 00 none, 01 write only, 10 read-check only, 11 write then read-check.
- seed  in  32  pattern seed, sampled on accepted start.
- busy  out  1  sequence in progress.
- done  out  1  level; set at sequence end, cleared on next accepted start.
- err_cnt  out  ERR_W  mismatching read words, saturating.
- fail_adr  out  5  address of first mismatch.
- fail_port  out  1  read port of first mismatch (0/1).
- rd_enb_0  out  1  read port 0 enable.
- rd_adr_0  out  5  read port 0 address.
- rd_dat_0  in  32  read port 0 data.
- rd_enb_1  out  1  read port 1 enable.
- rd_adr_1  out  5  read port 1 address.
- rd_dat_1  in  32  read port 1 data.
- wr_enb_0  out  1  write enable.
- wr_adr_0  out  5  write address.
- wr_dat_0  out  32  write data.

Behaviour:
- Reset (async, any time, including mid-sequence): state IDLE; all outputs 0; seed register and counters cleared; in-flight compares discarded.
- Pattern: pat(a) = seed_q + a, modulo 2^32, with a zero-extended.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Transitions:
  - IDLE/DONE + start sampled at edge N: capture seed, clear err_cnt/fail_*, done=0, busy=1 from N+1.
  - Next state from start: mode 00 -> DONE directly; 01 or 11 -> WRITE; 10 -> READ.
- WRITE: 32 cycles, cnt 0..31.
  - wr_enb_0=1, wr_adr_0=cnt, wr_dat_0=pat(cnt).
  - After cnt 31: mode 01 -> DONE; mode 11 -> READ.
- READ: 16 cycles, k 0..15.
  - rd_enb_0=1, rd_adr_0=2k; rd_enb_1=1, rd_adr_1=2k+1.
  - No write occurs in the same cycle as a read.
- DRAIN: RD_LAT cycles, enables low, waiting for the last compares; then DONE.
- DONE: busy=0, done=1; held until next accepted start.
- Outputs are 0 whenever their enable is 0.
- Compare pipeline:
  - Per port, valid+address shift register of depth RD_LAT.
  - When a tap is valid, compare rd_dat_x against pat(adr).
  - Each mismatching port increments err_cnt, so +2 if both ports fail in one cycle; saturates at 2^ERR_W-1.
  - First mismatch latches fail_adr/fail_port; if both ports fail in the same cycle, port 0 wins.
- Latency: busy cycles = 32·W + 16·R + RD_LAT·R, where W=1 if the mode writes and R=1 if the mode reads. Mode 00 gives 1 busy cycle.
- start while busy: ignored, with no effect on state or registers.

Optional Feature:
- Macro: RA_DRV_INVPASS_EN.
- Defined: mode 11 runs a second pass after the first DRAIN: WRITE and READ with pattern ~pat(a), then DRAIN, then DONE. err_cnt accumulates over both passes; fail_* still records the first mismatch overall.
- Undefined: single pass only.

Decomposition:
- Shared toysram header:
  - state encoding localparams;
  - mode codes (RA_DRV_MODE_NONE/WR/RD/WRRD);
  - array geometry constants: words 32, address width 5, data width 32.
- Sub-module ra_drv_chk: one instance per read port. Contains the delay line plus comparator and outputs mismatch+address. The parent arbitrates err_cnt and fail_* updates.

Test Plan:
- Against the RA_SIM array with RD_LAT=1, seed=0xA5A50000, mode 11 -> 32 writes with wr_dat_0 for adr 31 = 0xA5A5001F; busy for 49 cycles; done=1, err_cnt=0.
- Mode 10 after a prior mode 01 with seed 0x00000010 -> reads return 0x10+a; err_cnt=0; busy for 17 cycles.
- Force rd_dat_1 bit 31 inverted only when the captured address is 7 -> err_cnt=1, fail_adr=7, fail_port=1.
- Corrupt both ports at k=3 (adr 6 and 7) -> err_cnt=2, fail_adr=6, fail_port=0. Then corrupt all reads with ERR_W=4 -> err_cnt saturates at 15.
- Assert reset during WRITE cnt=10 -> all outputs 0 immediately. A following start with mode 00 -> busy for 1 cycle, done=1.
- start pulsed while busy, with mode 10 during a mode 01 run -> no effect. With RA_DRV_INVPASS_EN, mode 11 seed 0 -> second-pass write data at adr 0 = 0xFFFFFFFF; busy for 98 cycles; err_cnt=0.

Source files
------------

// File: rtl/ra_sdr_32x32_drv_pkg.sv
// ra_sdr_32x32_drv_pkg
//   Shared definitions for the 2R1W 32x32 SDR array driver: array geometry,
//   sequence mode codes, FSM state type and the test pattern function.
//   No ports.
package ra_sdr_32x32_drv_pkg;

    localparam int unsigned RA_WORDS = 32;
    localparam int unsigned RA_AW    = 5;
    localparam int unsigned RA_DW    = 32;

    localparam logic [1:0] RA_DRV_MODE_NONE = 2'b00;
    localparam logic [1:0] RA_DRV_MODE_WR   = 2'b01;
    localparam logic [1:0] RA_DRV_MODE_RD   = 2'b10;
    localparam logic [1:0] RA_DRV_MODE_WRRD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } ra_drv_state_e;

    // Word written to / expected from address adr: seed + adr, optionally inverted.
    function automatic logic [RA_DW-1:0] ra_drv_pat(input logic [RA_DW-1:0] seed,
                                                    input logic [RA_AW-1:0] adr,
                                                    input logic             inv);
        logic [RA_DW-1:0] p;
        p = seed + {{(RA_DW-RA_AW){1'b0}}, adr};
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ra_sdr_32x32_drv_if.sv
// ra_sdr_32x32_drv_if
//   Functional port bundle of the 2R1W 32x32 SDR test array.
//   master: driver side (drives enables/addresses/write data, receives read data)
//   slave : array side
//   Signals: rd_enb_0/rd_adr_0/rd_dat_0, rd_enb_1/rd_adr_1/rd_dat_1,
//            wr_enb_0/wr_adr_0/wr_dat_0.
interface ra_sdr_32x32_drv_if;
    import ra_sdr_32x32_drv_pkg::*;

    logic             rd_enb_0;
    logic [RA_AW-1:0] rd_adr_0;
    logic [RA_DW-1:0] rd_dat_0;
    logic             rd_enb_1;
    logic [RA_AW-1:0] rd_adr_1;
    logic [RA_DW-1:0] rd_dat_1;
    logic             wr_enb_0;
    logic [RA_AW-1:0] wr_adr_0;
    logic [RA_DW-1:0] wr_dat_0;

    modport master (
        output rd_enb_0, rd_adr_0, input rd_dat_0,
        output rd_enb_1, rd_adr_1, input rd_dat_1,
        output wr_enb_0, wr_adr_0, wr_dat_0
    );

    modport slave (
        input rd_enb_0, rd_adr_0, output rd_dat_0,
        input rd_enb_1, rd_adr_1, output rd_dat_1,
        input wr_enb_0, wr_adr_0, wr_dat_0
    );

endinterface

// File: rtl/ra_sdr_32x32_drv_chk.sv
// ra_drv_chk
//   Per-read-port checker: delays the issued (valid, address) by RD_LAT cycles
//   so it lines up with the returning read data, then compares the data
//   against the expected pattern.
//   Ports:
//     clk, rst      clock, async active-high reset (clears in-flight entries)
//     i_enb, i_adr  read issued this cycle and its address
//     i_dat         read data from the array
//     i_seed, i_inv pattern seed and inversion for the current pass
//     o_mis         mismatch on the word arriving this cycle
//     o_adr         address of the word arriving this cycle
module ra_drv_chk
    import ra_sdr_32x32_drv_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enb,
    input  logic [RA_AW-1:0] i_adr,
    input  logic [RA_DW-1:0] i_dat,
    input  logic [RA_DW-1:0] i_seed,
    input  logic             i_inv,
    output logic             o_mis,
    output logic [RA_AW-1:0] o_adr
);

    logic [RD_LAT-1:0] r_vld;
    logic [RA_AW-1:0]  r_adr [RD_LAT];
    logic [RA_DW-1:0]  w_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) r_adr[i] <= '0;
        end else begin
            r_vld[0] <= i_enb;
            r_adr[0] <= i_adr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_adr[i] <= r_adr[i-1];
            end
        end
    end

    always_comb begin
        o_adr = r_adr[RD_LAT-1];
        w_exp = ra_drv_pat(i_seed, o_adr, i_inv);
        o_mis = r_vld[RD_LAT-1] && (i_dat != w_exp);
    end

endmodule

// File: rtl/ra_sdr_32x32_drv.sv
// ra_sdr_32x32_drv
//   Traffic generator / checker for the 2R1W 32x32 SDR test array. Writes the
//   pattern seed+adr to all 32 words, reads them back two per cycle (even
//   address on port 0, odd on port 1) and counts mismatches.
//   Optional build macro RA_DRV_INVPASS_EN: mode 11 runs a second write/read
//   pass with the inverted pattern.
//   Ports:
//     clk, reset              clock, async active-high reset
//     start, mode, seed       host request (ignored while busy)
//     busy, done              sequence status
//     err_cnt                 saturating mismatch count
//     fail_adr, fail_port     location of the first mismatch
//     arr                     array functional ports (master side)
module ra_sdr_32x32_drv
    import ra_sdr_32x32_drv_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [RA_DW-1:0]     seed,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [RA_AW-1:0]     fail_adr,
    output logic                 fail_port,
    ra_sdr_32x32_drv_if.master   arr
);

    ra_drv_state_e    r_state, w_state_nx;
    logic [4:0]       r_cnt;
    logic [1:0]       r_mode;
    logic [RA_DW-1:0] r_seed;
    logic             r_pass;
    logic             r_acc;
    logic [ERR_W-1:0] r_err;
    logic [RA_AW-1:0] r_fail_adr;
    logic             r_fail_port;
    logic             r_fail_seen;

    logic             w_accept;
    logic             w_pass_set;
    logic             w_mis0, w_mis1;
    logic [RA_AW-1:0] w_adr0, w_adr1;
    logic [1:0]       w_inc;
    logic [ERR_W:0]   w_sum;
    logic [ERR_W-1:0] w_err_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_accept     = 1'b0;
        w_pass_set   = 1'b0;
        arr.wr_enb_0 = 1'b0;
        arr.wr_adr_0 = '0;
        arr.wr_dat_0 = '0;
        arr.rd_enb_0 = 1'b0;
        arr.rd_adr_0 = '0;
        arr.rd_enb_1 = 1'b0;
        arr.rd_adr_1 = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    case (mode)
                        RA_DRV_MODE_NONE: w_state_nx = ST_DONE;
                        RA_DRV_MODE_RD:   w_state_nx = ST_READ;
                        default:          w_state_nx = ST_WRITE;
                    endcase
                end
            end
            ST_WRITE: begin
                arr.wr_enb_0 = 1'b1;
                arr.wr_adr_0 = r_cnt;
                arr.wr_dat_0 = ra_drv_pat(r_seed, r_cnt, r_pass);
                if (r_cnt == 5'(RA_WORDS-1))
                    w_state_nx = (r_mode == RA_DRV_MODE_WR) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                arr.rd_enb_0 = 1'b1;
                arr.rd_adr_0 = {r_cnt[3:0], 1'b0};
                arr.rd_enb_1 = 1'b1;
                arr.rd_adr_1 = {r_cnt[3:0], 1'b1};
                if (r_cnt == 5'(RA_WORDS/2-1)) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_cnt == 5'(RD_LAT-1)) begin
`ifdef RA_DRV_INVPASS_EN
                    if (r_mode == RA_DRV_MODE_WRRD && !r_pass) begin
                        w_state_nx = ST_WRITE;
                        w_pass_set = 1'b1;
                    end else begin
                        w_state_nx = ST_DONE;
                    end
`else
                    w_state_nx = ST_DONE;
`endif
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // One counter serves WRITE word index, READ pair index and DRAIN delay;
    // it restarts at every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_state_nx != r_state)
            r_cnt <= '0;
        else if (r_state inside {ST_WRITE, ST_READ, ST_DRAIN})
            r_cnt <= r_cnt + 5'd1;
        else
            r_cnt <= '0;
    end

    ra_drv_chk #(.RD_LAT(RD_LAT)) u_chk0 (
        .clk(clk), .rst(reset),
        .i_enb(arr.rd_enb_0), .i_adr(arr.rd_adr_0), .i_dat(arr.rd_dat_0),
        .i_seed(r_seed), .i_inv(r_pass),
        .o_mis(w_mis0), .o_adr(w_adr0)
    );

    ra_drv_chk #(.RD_LAT(RD_LAT)) u_chk1 (
        .clk(clk), .rst(reset),
        .i_enb(arr.rd_enb_1), .i_adr(arr.rd_adr_1), .i_dat(arr.rd_dat_1),
        .i_seed(r_seed), .i_inv(r_pass),
        .o_mis(w_mis1), .o_adr(w_adr1)
    );

    // Both ports may fail in one cycle, so the increment is 0..2 and the
    // extra sum bit flags overflow for saturation.
    always_comb begin
        w_inc    = {1'b0, w_mis0} + {1'b0, w_mis1};
        w_sum    = {1'b0, r_err} + (ERR_W+1)'(w_inc);
        w_err_nx = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= RA_DRV_MODE_NONE;
            r_seed      <= '0;
            r_pass      <= 1'b0;
            r_acc       <= 1'b0;
            r_err       <= '0;
            r_fail_adr  <= '0;
            r_fail_port <= 1'b0;
            r_fail_seen <= 1'b0;
        end else begin
            r_acc <= w_accept;
            if (w_accept) begin
                r_mode      <= mode;
                r_seed      <= seed;
                r_pass      <= 1'b0;
                r_err       <= '0;
                r_fail_adr  <= '0;
                r_fail_port <= 1'b0;
                r_fail_seen <= 1'b0;
            end else begin
                if (w_pass_set) r_pass <= 1'b1;
                r_err <= w_err_nx;
                if (!r_fail_seen && (w_mis0 || w_mis1)) begin
                    r_fail_seen <= 1'b1;
                    r_fail_adr  <= w_mis0 ? w_adr0 : w_adr1;
                    r_fail_port <= !w_mis0;
                end
            end
        end
    end

    // r_acc stretches busy over the accept cycle so mode 00 still reports
    // one busy cycle before done rises.
    assign busy      = r_acc || (r_state inside {ST_WRITE, ST_READ, ST_DRAIN});
    assign done      = (r_state == ST_DONE) && !r_acc;
    assign err_cnt   = r_err;
    assign fail_adr  = r_fail_adr;
    assign fail_port = r_fail_port;

endmodule

// File: tb/tb_ra_sdr_32x32_drv.sv
module tb_ra_sdr_32x32_drv;
    import ra_sdr_32x32_drv_pkg::*;

`ifdef RA_DRV_INVPASS_EN
    localparam int BUSY_WRRD = 98;
`else
    localparam int BUSY_WRRD = 49;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;

    logic        busy_a, done_a, fport_a;
    logic [7:0]  err_a;
    logic [4:0]  fadr_a;
    logic        busy_b, done_b, fport_b;
    logic [3:0]  err_b;
    logic [4:0]  fadr_b;

    ra_sdr_32x32_drv_if arr_a ();
    ra_sdr_32x32_drv_if arr_b ();

    ra_sdr_32x32_drv #(.RD_LAT(1), .ERR_W(8)) u_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .busy(busy_a), .done(done_a), .err_cnt(err_a),
        .fail_adr(fadr_a), .fail_port(fport_a), .arr(arr_a)
    );

    ra_sdr_32x32_drv #(.RD_LAT(3), .ERR_W(4)) u_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .busy(busy_b), .done(done_b), .err_cnt(err_b),
        .fail_adr(fadr_b), .fail_port(fport_b), .arr(arr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int corrupt = 0;

    typedef struct { logic [4:0] adr; logic [31:0] dat; } wr_t;
    wr_t        wq[$];
    logic [4:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read-data corruption applied by the array models.
    function automatic logic [31:0] cmask(input logic [4:0] a, input logic p);
        logic [31:0] m;
        m = 32'h0;
        case (corrupt)
            1: if (p && a == 5'd7) m = 32'h8000_0000;
            2: if ((!p && a == 5'd6) || (p && a == 5'd7)) m = 32'h8000_0000;
            3: m = 32'h8000_0000;
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    // Array model for DUT A: read latency 1.
    logic [31:0] mem_a [32];
    always @(posedge clk) begin
        if (arr_a.wr_enb_0) mem_a[arr_a.wr_adr_0] <= arr_a.wr_dat_0;
        if (arr_a.rd_enb_0) arr_a.rd_dat_0 <= mem_a[arr_a.rd_adr_0] ^ cmask(arr_a.rd_adr_0, 1'b0);
        if (arr_a.rd_enb_1) arr_a.rd_dat_1 <= mem_a[arr_a.rd_adr_1] ^ cmask(arr_a.rd_adr_1, 1'b1);
    end

    // Array model for DUT B: read latency 3.
    logic [31:0] mem_b [32];
    logic [31:0] pb0 [3];
    logic [31:0] pb1 [3];
    always @(posedge clk) begin
        if (arr_b.wr_enb_0) mem_b[arr_b.wr_adr_0] <= arr_b.wr_dat_0;
        pb0[0] <= arr_b.rd_enb_0 ? (mem_b[arr_b.rd_adr_0] ^ cmask(arr_b.rd_adr_0, 1'b0)) : 32'h0;
        pb1[0] <= arr_b.rd_enb_1 ? (mem_b[arr_b.rd_adr_1] ^ cmask(arr_b.rd_adr_1, 1'b1)) : 32'h0;
        pb0[1] <= pb0[0];
        pb0[2] <= pb0[1];
        pb1[1] <= pb1[0];
        pb1[2] <= pb1[1];
    end
    assign arr_b.rd_dat_0 = pb0[2];
    assign arr_b.rd_dat_1 = pb1[2];

    // Scoreboard monitor on DUT A's array ports.
    always @(negedge clk) begin : mon
        wr_t        w;
        logic [4:0] k;
        if (reset === 1'b0) begin
            chk("wr_rd_excl", 32'(arr_a.wr_enb_0 & arr_a.rd_enb_0), 32'h0);
            if (arr_a.wr_enb_0) begin
                if (wq.size() == 0) chk("wr_unexpected", 32'(wq.size()), 32'd1);
                else begin
                    w = wq.pop_front();
                    chk("wr_adr", 32'(arr_a.wr_adr_0), 32'(w.adr));
                    chk("wr_dat", arr_a.wr_dat_0, w.dat);
                end
            end else begin
                chk("wr_idle_adr", 32'(arr_a.wr_adr_0), 32'h0);
                chk("wr_idle_dat", arr_a.wr_dat_0, 32'h0);
            end
            chk("rd_enb_pair", 32'(arr_a.rd_enb_1), 32'(arr_a.rd_enb_0));
            if (arr_a.rd_enb_0) begin
                if (rq.size() == 0) chk("rd_unexpected", 32'(rq.size()), 32'd1);
                else begin
                    k = rq.pop_front();
                    chk("rd_adr0", 32'(arr_a.rd_adr_0), 32'(k));
                    chk("rd_adr1", 32'(arr_a.rd_adr_1), 32'(k) + 32'd1);
                end
            end else begin
                chk("rd_idle_adr0", 32'(arr_a.rd_adr_0), 32'h0);
                chk("rd_idle_adr1", 32'(arr_a.rd_adr_1), 32'h0);
            end
        end
    end

    task automatic push_pass(input logic [1:0] m, input logic [31:0] s, input logic inv);
        logic [31:0] p;
        if (m == RA_DRV_MODE_WR || m == RA_DRV_MODE_WRRD)
            for (int a = 0; a < 32; a++) begin
                p = s + 32'(a);
                wq.push_back('{adr: 5'(a), dat: (inv ? ~p : p)});
            end
        if (m == RA_DRV_MODE_RD || m == RA_DRV_MODE_WRRD)
            for (int k = 0; k < 16; k++) rq.push_back(5'(2 * k));
    endtask

    task automatic start_seq(input logic [1:0] m, input logic [31:0] s);
        push_pass(m, s, 1'b0);
`ifdef RA_DRV_INVPASS_EN
        if (m == RA_DRV_MODE_WRRD) push_pass(m, s, 1'b1);
`endif
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'b00;
        seed  = 32'h0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy, input int pulse_at,
                             input logic [31:0] exp_err, input logic [31:0] exp_fadr,
                             input logic [31:0] exp_fport, input logic [31:0] exp_err_b);
        int n;
        int m;
        n = 0;
        chk({tag, "_done_clr"}, 32'(done_a), 32'h0);
        while (busy_a === 1'b1 && n < 300) begin
            n++;
            if (n == pulse_at) begin
                start = 1'b1;
                mode  = RA_DRV_MODE_RD;
                seed  = 32'hFFFF_0000;
            end else begin
                start = 1'b0;
                mode  = 2'b00;
                seed  = 32'h0;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({tag, "_done"}, 32'(done_a), 32'h1);
        chk({tag, "_err"}, 32'(err_a), exp_err);
        chk({tag, "_fail_adr"}, 32'(fadr_a), exp_fadr);
        chk({tag, "_fail_port"}, 32'(fport_a), exp_fport);
        chk({tag, "_wq_left"}, 32'(wq.size()), 32'h0);
        chk({tag, "_rq_left"}, 32'(rq.size()), 32'h0);
        m = 0;
        while (busy_b === 1'b1 && m < 10) begin
            m++;
            @(posedge clk); #1;
        end
        chk({tag, "_b_idle"}, 32'(busy_b), 32'h0);
        chk({tag, "_b_err"}, 32'(err_b), exp_err_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int g;
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        seed  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_fail_adr", 32'(fadr_a), 32'h0);
        chk("rst_fail_port", 32'(fport_a), 32'h0);
        chk("rst_wr_enb", 32'(arr_a.wr_enb_0), 32'h0);
        chk("rst_rd_enb", 32'({arr_a.rd_enb_0, arr_a.rd_enb_1}), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write then read-check, clean array.
        start_seq(RA_DRV_MODE_WRRD, 32'hA5A5_0000);
        wait_done("wrrd", BUSY_WRRD, -1, 32'd0, 32'd0, 32'd0, 32'd0);

        // Write-only, with an ignored start (mode 10) pulsed mid-run.
        start_seq(RA_DRV_MODE_WR, 32'h0000_0010);
        wait_done("wr_pulse", 32, 10, 32'd0, 32'd0, 32'd0, 32'd0);

        // Read-check of the previously written data.
        start_seq(RA_DRV_MODE_RD, 32'h0000_0010);
        wait_done("rd_clean", 17, -1, 32'd0, 32'd0, 32'd0, 32'd0);

        corrupt = 1;
        start_seq(RA_DRV_MODE_RD, 32'h0000_0010);
        wait_done("rd_p1a7", 17, -1, 32'd1, 32'd7, 32'd1, 32'd1);

        corrupt = 2;
        start_seq(RA_DRV_MODE_RD, 32'h0000_0010);
        wait_done("rd_both", 17, -1, 32'd2, 32'd6, 32'd0, 32'd2);

        corrupt = 3;
        start_seq(RA_DRV_MODE_RD, 32'h0000_0010);
        wait_done("rd_all", 17, -1, 32'd32, 32'd0, 32'd0, 32'd15);
        corrupt = 0;

        // Reset in the middle of WRITE.
        start_seq(RA_DRV_MODE_WR, 32'h0000_0010);
        g = 0;
        while (!(arr_a.wr_enb_0 === 1'b1 && arr_a.wr_adr_0 === 5'd10) && g < 50) begin
            g++;
            @(posedge clk); #1;
        end
        chk("mid_wr_reached", 32'(arr_a.wr_adr_0), 32'd10);
        #2;
        reset = 1'b1;
        wq.delete();
        rq.delete();
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        chk("mid_rst_done", 32'(done_a), 32'h0);
        chk("mid_rst_wr_enb", 32'(arr_a.wr_enb_0), 32'h0);
        chk("mid_rst_wr_adr", 32'(arr_a.wr_adr_0), 32'h0);
        chk("mid_rst_wr_dat", arr_a.wr_dat_0, 32'h0);
        chk("mid_rst_err", 32'(err_a), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        start_seq(RA_DRV_MODE_NONE, 32'h1234_5678);
        wait_done("none", 1, -1, 32'd0, 32'd0, 32'd0, 32'd0);

        start_seq(RA_DRV_MODE_WRRD, 32'h0000_0000);
        wait_done("wrrd_seed0", BUSY_WRRD, -1, 32'd0, 32'd0, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
